// File: rtl/reg_issue_ctrl_pkg.sv
// Shared types for the LC-3b register issue controller.
package lc3b_types;

  typedef logic [2:0] lc3b_reg;
  typedef logic [1:0] pend_cnt_t;

  localparam int unsigned MAX_PEND_DEFAULT = 3;

  typedef enum logic {
    EMPTY = 1'b0,
    HELD  = 1'b1
  } issue_state_t;

  typedef struct packed {
    lc3b_reg sr1;
    lc3b_reg sr2;
    lc3b_reg dr;
    logic    sr1_use;
    logic    sr2_use;
    logic    dr_we;
    logic    cc_use;
    logic    cc_we;
  } held_instr_t;

endpackage

// File: rtl/reg_issue_ctrl_pend_counter.sv
// Pending-write counter for one register (or the condition codes).
module pend_counter
  import lc3b_types::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      inc,
  input  logic      dec,
  output pend_cnt_t count,
  output logic      err
);

  // A retirement with nothing pending is a protocol error.
  always_comb begin
    err = dec && (count == '0);
  end

  // Issue and writeback in the same cycle cancel; decrement at zero is ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (inc && !dec) begin
      if (count != '1) count <= count + 2'd1;
    end else if (dec && !inc) begin
      if (count != '0) count <= count - 2'd1;
    end
  end

endmodule

// File: rtl/reg_issue_ctrl.sv
// Single-entry issue stage with per-register pending-write scoreboard.
module reg_issue_ctrl
  import lc3b_types::*;
#(
  parameter int unsigned MAX_PEND = MAX_PEND_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  lc3b_reg     in_sr1,
  input  lc3b_reg     in_sr2,
  input  lc3b_reg     in_dr,
  input  logic        in_sr1_use,
  input  logic        in_sr2_use,
  input  logic        in_dr_we,
  input  logic        in_cc_use,
  input  logic        in_cc_we,
  output logic        out_valid,
  input  logic        out_ready,
  output lc3b_reg     out_dr,
  output logic        out_dr_we,
  output logic        out_cc_we,
  input  logic        wb_valid,
  input  logic        wb_dr_we,
  input  logic        wb_cc_we,
  input  lc3b_reg     wb_dr,
  input  logic        flush,
  output logic [7:0]  busy_vec,
  output logic [15:0] stall_cnt,
  output logic        wb_err
);

  localparam pend_cnt_t MAX_CNT = pend_cnt_t'(MAX_PEND);

  issue_state_t state, state_next;
  held_instr_t  held;
  pend_cnt_t    reg_cnt [8];
  logic [7:0]   reg_inc, reg_dec, reg_err;
  pend_cnt_t    cc_cnt;
  logic         cc_inc, cc_dec, cc_err;
  logic         hazard, issue, capture;

  for (genvar i = 0; i < 8; i++) begin : g_reg
    pend_counter u_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (reg_inc[i]),
      .dec   (reg_dec[i]),
      .count (reg_cnt[i]),
      .err   (reg_err[i])
    );
  end

  pend_counter u_cc_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (cc_inc),
    .dec   (cc_dec),
    .count (cc_cnt),
    .err   (cc_err)
  );

  // Hazard check uses the counters as they stand before this cycle's updates.
  always_comb begin
    hazard = (held.sr1_use && (reg_cnt[held.sr1] != '0)) ||
             (held.sr2_use && (reg_cnt[held.sr2] != '0)) ||
             (held.cc_use  && (cc_cnt != '0)) ||
             (held.dr_we   && (reg_cnt[held.dr] == MAX_CNT)) ||
             (held.cc_we   && (cc_cnt == MAX_CNT));
  end

  // Handshakes and next state; flush suppresses both issue and capture.
  always_comb begin
    state_next = state;
    out_valid  = (state == HELD) && !hazard && !flush;
    issue      = out_valid && out_ready;
    in_ready   = !flush && ((state == EMPTY) || issue);
    capture    = in_valid && in_ready;
    if (flush)        state_next = EMPTY;
    else if (capture) state_next = HELD;
    else if (issue)   state_next = EMPTY;
  end

  // Counter increment/decrement strobes and busy summary.
  always_comb begin
    reg_inc  = '0;
    reg_dec  = '0;
    busy_vec = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      reg_inc[i]  = issue && held.dr_we && (held.dr == i[2:0]);
      reg_dec[i]  = wb_valid && wb_dr_we && (wb_dr == i[2:0]);
      busy_vec[i] = (reg_cnt[i] != '0);
    end
    cc_inc = issue && held.cc_we;
    cc_dec = wb_valid && wb_cc_we;
  end

  assign out_dr    = held.dr;
  assign out_dr_we = held.dr_we;
  assign out_cc_we = held.cc_we;

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= EMPTY;
    else     state <= state_next;
  end

  // Holding register loads on every accepted instruction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      held <= '0;
    end else if (capture) begin
      held <= '{sr1: in_sr1, sr2: in_sr2, dr: in_dr,
                sr1_use: in_sr1_use, sr2_use: in_sr2_use,
                dr_we: in_dr_we, cc_use: in_cc_use, cc_we: in_cc_we};
    end
  end

  // Saturating count of cycles an instruction sat in HELD without issuing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if ((state == HELD) && !issue && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

  // Sticky writeback error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      wb_err <= 1'b0;
    else if ((|reg_err) || cc_err) wb_err <= 1'b1;
  end

endmodule

// File: tb/tb_reg_issue_ctrl.sv
// Directed bench for reg_issue_ctrl: vector table plus hand-written sequences.
module tb_reg_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid, in_ready;
  logic [2:0]  in_sr1, in_sr2, in_dr;
  logic        in_sr1_use, in_sr2_use, in_dr_we, in_cc_use, in_cc_we;
  logic        out_valid, out_ready;
  logic [2:0]  out_dr;
  logic        out_dr_we, out_cc_we;
  logic        wb_valid, wb_dr_we, wb_cc_we;
  logic [2:0]  wb_dr;
  logic        flush;
  logic [7:0]  busy_vec;
  logic [15:0] stall_cnt;
  logic        wb_err;

  int errors = 0;
  int checks = 0;

  reg_issue_ctrl #(.MAX_PEND(3)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sr1(in_sr1), .in_sr2(in_sr2), .in_dr(in_dr),
    .in_sr1_use(in_sr1_use), .in_sr2_use(in_sr2_use), .in_dr_we(in_dr_we),
    .in_cc_use(in_cc_use), .in_cc_we(in_cc_we),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_dr(out_dr), .out_dr_we(out_dr_we), .out_cc_we(out_cc_we),
    .wb_valid(wb_valid), .wb_dr_we(wb_dr_we), .wb_cc_we(wb_cc_we), .wb_dr(wb_dr),
    .flush(flush), .busy_vec(busy_vec), .stall_cnt(stall_cnt), .wb_err(wb_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       iv;
    logic [2:0] sr1; logic u1;
    logic [2:0] sr2; logic u2;
    logic [2:0] dr;  logic we;
    logic       ccu, ccw, ordy, wbv;
    logic [2:0] wbdr; logic wbwe, wbcc, fl;
    logic       e_ir, e_ov;
    logic [2:0] e_dr;
    logic [7:0] e_busy;
    logic [15:0] e_stall;
    logic       e_err;
  } vec_t;

  vec_t tbl [13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    in_valid = 0; in_sr1 = 0; in_sr2 = 0; in_dr = 0;
    in_sr1_use = 0; in_sr2_use = 0; in_dr_we = 0; in_cc_use = 0; in_cc_we = 0;
    out_ready = 0; wb_valid = 0; wb_dr_we = 0; wb_cc_we = 0; wb_dr = 0; flush = 0;
  endtask

  task automatic set_instr(input logic [2:0] s1, input logic u1, input logic [2:0] s2,
                           input logic u2, input logic [2:0] d, input logic we,
                           input logic ccu, input logic ccw);
    in_valid = 1; in_sr1 = s1; in_sr1_use = u1; in_sr2 = s2; in_sr2_use = u2;
    in_dr = d; in_dr_we = we; in_cc_use = ccu; in_cc_we = ccw;
  endtask

  task automatic set_wb(input logic v, input logic [2:0] d);
    wb_valid = v; wb_dr_we = v; wb_dr = d; wb_cc_we = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    clear_in();
    tick();
    tick();
    rst = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    // iv sr1 u1 sr2 u2 dr we ccu ccw ordy wbv wbdr wbwe wbcc fl | ir ov dr busy stall err
    tbl[0]  = '{1,0,1,0,1,1,1,0,0,1,0,0,0,0,0, 1,0,0,8'h00,0,0}; // capture ADD R1
    tbl[1]  = '{1,1,1,0,0,2,1,0,0,1,0,0,0,0,0, 1,1,1,8'h00,0,0}; // issue R1 writer, capture R2<-R1
    tbl[2]  = '{0,0,0,0,0,0,0,0,0,1,0,0,0,0,0, 0,0,2,8'h02,0,0}; // RAW stall
    tbl[3]  = '{0,0,0,0,0,0,0,0,0,1,1,1,1,0,0, 0,0,2,8'h02,1,0}; // wb R1, still blocked
    tbl[4]  = '{0,0,0,0,0,0,0,0,0,1,0,0,0,0,0, 1,1,2,8'h00,2,0}; // issues 1 cycle after wb
    tbl[5]  = '{0,0,0,0,0,0,0,0,0,0,1,2,1,0,0, 1,0,0,8'h04,2,0}; // wb R2
    tbl[6]  = '{0,0,0,0,0,0,0,0,0,0,1,7,1,0,0, 1,0,0,8'h00,2,0}; // wb R7 at zero
    tbl[7]  = '{0,0,0,0,0,0,0,0,0,0,0,0,0,0,0, 1,0,0,8'h00,2,1}; // error flagged
    tbl[8]  = '{1,0,0,0,0,0,0,0,1,1,0,0,0,0,0, 1,0,0,8'h00,2,1}; // capture CC writer
    tbl[9]  = '{1,0,0,0,0,0,0,1,0,1,0,0,0,0,0, 1,1,0,8'h00,2,1}; // issue it, capture CC reader
    tbl[10] = '{0,0,0,0,0,0,0,0,0,1,1,0,0,1,0, 0,0,0,8'h00,2,1}; // CC hazard, wb CC
    tbl[11] = '{0,0,0,0,0,0,0,0,0,1,0,0,0,0,0, 1,1,0,8'h00,3,1}; // CC reader issues
    tbl[12] = '{0,0,0,0,0,0,0,0,0,0,0,0,0,0,0, 1,0,0,8'h00,3,1}; // idle, error sticky

    clear_in();
    #3;
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_busy", 32'(busy_vec), 32'h00);
    check("reset_stall", 32'(stall_cnt), 32'd0);
    check("reset_err", 32'(wb_err), 32'd0);
    do_reset();

    // Table-driven main sequence
    for (int i = 0; i < 13; i++) begin
      in_valid = tbl[i].iv; in_sr1 = tbl[i].sr1; in_sr1_use = tbl[i].u1;
      in_sr2 = tbl[i].sr2; in_sr2_use = tbl[i].u2; in_dr = tbl[i].dr;
      in_dr_we = tbl[i].we; in_cc_use = tbl[i].ccu; in_cc_we = tbl[i].ccw;
      out_ready = tbl[i].ordy; wb_valid = tbl[i].wbv; wb_dr = tbl[i].wbdr;
      wb_dr_we = tbl[i].wbwe; wb_cc_we = tbl[i].wbcc; flush = tbl[i].fl;
      #3;
      check($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(tbl[i].e_ir));
      check($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].e_ov));
      if (tbl[i].e_ov) check($sformatf("v%0d_out_dr", i), 32'(out_dr), 32'(tbl[i].e_dr));
      check($sformatf("v%0d_busy", i), 32'(busy_vec), 32'(tbl[i].e_busy));
      check($sformatf("v%0d_stall", i), 32'(stall_cnt), 32'(tbl[i].e_stall));
      check($sformatf("v%0d_err", i), 32'(wb_err), 32'(tbl[i].e_err));
      tick();
    end

    // WAW saturation on R3
    do_reset();
    out_ready = 1;
    set_instr(0, 0, 0, 0, 3, 1, 0, 0);
    repeat (4) tick();
    in_valid = 0;
    #3;
    check("waw_sat_out_valid", 32'(out_valid), 32'd0);
    check("waw_sat_in_ready", 32'(in_ready), 32'd0);
    check("waw_sat_busy", 32'(busy_vec), 32'h08);
    tick();
    set_wb(1, 3);
    #3;
    check("waw_wb_cycle_out_valid", 32'(out_valid), 32'd0);
    tick();
    set_wb(0, 0);
    #3;
    check("waw_release_out_valid", 32'(out_valid), 32'd1);
    check("waw_release_out_dr", 32'(out_dr), 32'd3);
    check("waw_stall", 32'(stall_cnt), 32'd2);
    tick();
    #3;
    check("waw_after_busy", 32'(busy_vec), 32'h08);
    check("waw_after_in_ready", 32'(in_ready), 32'd1);

    // Simultaneous issue and writeback on R5
    do_reset();
    out_ready = 1;
    set_instr(0, 0, 0, 0, 5, 1, 0, 0);
    tick();
    tick();
    in_valid = 0;
    set_wb(1, 5);
    #3;
    check("simul_out_valid", 32'(out_valid), 32'd1);
    check("simul_busy_before", 32'(busy_vec), 32'h20);
    tick();
    set_wb(0, 0);
    #3;
    check("simul_busy_after", 32'(busy_vec), 32'h20);
    check("simul_err", 32'(wb_err), 32'd0);
    set_wb(1, 5);
    tick();
    set_wb(0, 0);
    #3;
    check("simul_drain_busy", 32'(busy_vec), 32'h00);
    check("simul_drain_err", 32'(wb_err), 32'd0);
    set_wb(1, 5);
    tick();
    set_wb(0, 0);
    #3;
    check("extra_wb_err", 32'(wb_err), 32'd1);
    check("extra_wb_busy", 32'(busy_vec), 32'h00);
    tick();
    #3;
    check("err_sticky", 32'(wb_err), 32'd1);

    // Flush of a stalled instruction
    do_reset();
    out_ready = 1;
    set_instr(0, 0, 0, 0, 1, 1, 0, 0);
    tick();
    set_instr(1, 1, 0, 0, 2, 1, 0, 0);
    tick();
    in_valid = 0;
    #3;
    check("flush_pre_out_valid", 32'(out_valid), 32'd0);
    check("flush_pre_busy", 32'(busy_vec), 32'h02);
    tick();
    flush = 1;
    #3;
    check("flush_out_valid", 32'(out_valid), 32'd0);
    check("flush_in_ready", 32'(in_ready), 32'd0);
    tick();
    flush = 0;
    set_wb(1, 1);
    #3;
    check("flush_empty_in_ready", 32'(in_ready), 32'd1);
    check("flush_empty_out_valid", 32'(out_valid), 32'd0);
    check("flush_busy_kept", 32'(busy_vec), 32'h02);
    tick();
    set_wb(0, 0);
    #3;
    check("flush_no_issue_ov", 32'(out_valid), 32'd0);
    check("flush_no_issue_busy", 32'(busy_vec), 32'h00);
    tick();
    #3;
    check("flush_no_issue_busy2", 32'(busy_vec), 32'h00);

    // Asynchronous reset mid-operation
    do_reset();
    out_ready = 1;
    set_instr(0, 0, 0, 0, 1, 1, 0, 0);
    tick();
    set_instr(0, 0, 0, 0, 2, 1, 0, 0);
    tick();
    set_instr(0, 0, 0, 0, 5, 1, 0, 0);
    tick();
    set_instr(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    in_valid = 0;
    out_ready = 0;
    #3;
    check("rst_pre_busy", 32'(busy_vec), 32'h26);
    check("rst_pre_out_valid", 32'(out_valid), 32'd1);
    #1;
    rst = 1;
    #1;
    check("rst_async_out_valid", 32'(out_valid), 32'd0);
    check("rst_async_busy", 32'(busy_vec), 32'h00);
    check("rst_async_in_ready", 32'(in_ready), 32'd1);
    check("rst_async_stall", 32'(stall_cnt), 32'd0);
    out_ready = 1;
    tick();
    rst = 0;
    #3;
    check("rst_after_out_valid", 32'(out_valid), 32'd0);
    check("rst_after_busy", 32'(busy_vec), 32'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reg_issue_ctrl.md
REG_ISSUE_CTRL -- requirements
Module: reg_issue_ctrl

Interface
REQ-001 SHALL have parameter MAX_PEND, default 3, meaning the maximum in-flight writes per register (2-bit counters).
REQ-002 SHALL have port clk  input  1  system clock, rising edge; single clock domain.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port in_valid  input  1  decoded instruction present.
REQ-005 SHALL have port in_ready  output  1  block accepts the decoded instruction this cycle.
REQ-006 SHALL have port in_sr1, in_sr2, in_dr  input  3 each  source and destination register indices (lc3b_reg).
REQ-007 SHALL have port in_sr1_use, in_sr2_use, in_dr_we, in_cc_use, in_cc_we  input  1 each  operand/CC read and write flags.
REQ-008 SHALL have port out_valid  output  1  held instruction issued to execute this cycle.
REQ-009 SHALL have port out_ready  input  1  execute stage accepts.
REQ-010 SHALL have port out_dr, out_dr_we, out_cc_we  output  3/1/1  registered copy of the issued instruction's write fields.
REQ-011 SHALL have port wb_valid, wb_dr_we, wb_cc_we  input  1 each  writeback retires a write this cycle.
REQ-012 SHALL have port wb_dr  input  3  retiring destination index.
REQ-013 SHALL have port flush  input  1  squash the held (not yet issued) instruction.
REQ-014 SHALL have port busy_vec  output  8  bit i = register i has pending count > 0.
REQ-015 SHALL have port stall_cnt  output  16  cycles spent in STALL, saturating.
REQ-016 SHALL have port wb_err  output  1  sticky: writeback to a register or CC with zero pending.

Function
REQ-017 SHALL keep eight 2-bit pending counters (one per register) plus one CC pending counter.
REQ-018 SHALL hold at most one instruction in a holding register; FSM states EMPTY and HELD.
REQ-019 SHALL assert in_ready in EMPTY, and in HELD only when the held instruction issues in the same cycle.
REQ-020 SHALL capture in_* into the holding register on in_valid && in_ready; EMPTY->HELD.
REQ-021 SHALL declare a hazard when any used source (sr1/sr2/CC) has count > 0, or a written target (dr/CC) has count == MAX_PEND.
REQ-022 SHALL assert out_valid in HELD when no hazard exists; out_* are driven combinationally from the holding register.
REQ-023 SHALL issue on out_valid && out_ready: increment the dr counter if dr_we, increment the CC counter if cc_we, and go to EMPTY unless a new instruction is captured the same cycle.
REQ-024 SHALL decrement the wb_dr counter on wb_valid && wb_dr_we, and the CC counter on wb_valid && wb_cc_we.
REQ-025 SHALL leave a counter unchanged when issue increments and writeback decrements it in the same cycle.
REQ-026 SHALL evaluate hazards against pre-update counters: a same-cycle writeback does not unblock issue until the next cycle (1-cycle release latency).
REQ-027 SHALL ignore a decrement at count 0, leave the counter at 0, and set wb_err until reset.
REQ-028 SHALL drop the held instruction on flush (HELD->EMPTY) without touching counters; flush takes priority over issue, and in_ready is 0 during flush.
REQ-029 SHALL increment stall_cnt each cycle in HELD without out_valid && out_ready, saturating at 16'hFFFF.

Reset
REQ-030 SHALL on rst force state EMPTY, all counters 0, busy_vec 8'h00, stall_cnt 0, wb_err 0, out_valid 0, in_ready 1, and holding register 0, independently of clk.
REQ-031 SHALL discard any instruction in flight when rst is asserted mid-operation, with no issue on the reset cycle.

Structure
REQ-032 SHALL place MAX_PEND default, the pend_cnt_t 2-bit typedef, and the FSM state enum in lc3b_types; lc3b_reg is reused.
REQ-033 SHALL instantiate a sub-module pend_counter (inc, dec, count, err) nine times: eight registers plus CC.

Verification
REQ-034 SHALL cover RAW: issue ADD R1 (dr_we), then ADD R2<-R1 -> out_valid=0 and stall_cnt increments until wb R1; second issue exactly 1 cycle after wb.
REQ-035 SHALL cover WAW saturation: three issues writing R3 with no wb -> busy_vec=8'h08, count 3, fourth R3 writer stalls; one wb R3 -> issues next cycle.
REQ-036 SHALL cover simultaneous events: issue writing R5 in the same cycle as wb R5 at count 1 -> count remains 1, wb_err=0.
REQ-037 SHALL cover error: wb R7 with count 0 -> wb_err=1 and stays 1; counter remains 0.
REQ-038 SHALL cover flush: held stalled instruction with flush=1 -> EMPTY next cycle, no issue, counters unchanged.
REQ-039 SHALL cover reset mid-operation: rst asserted with busy_vec=8'h26 -> busy_vec=0, out_valid=0 immediately (asynchronous).
